// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch sequencer slice:
//   - state_e   : 3-bit FSM state encoding
//   - ctrl_t    : bundle of the registered control outputs
//   - defaults  : ACK_TIMEOUT and counter width
//   - decode_ctrl(): maps a state to the control levels it drives
package fetch_sequencer_pkg;

    localparam int DEFAULT_ACK_TIMEOUT = 15;
    localparam int DEFAULT_CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_ADDR = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_LATCH      = 3'd3,
        ST_EXECUTE    = 3'd4,
        ST_JUMP       = 3'd5,
        ST_HALTED     = 3'd6,
        ST_FAULT      = 3'd7
    } state_e;

    typedef struct packed {
        logic mem_req;
        logic pc_not_read;
        logic pc_not_write;
        logic pc_inc;
        logic ir_load;
        logic ex_start;
        logic halted;
        logic fault;
    } ctrl_t;

    // Everything inactive: the PC's active-low lines sit high.
    localparam ctrl_t CTRL_RESET = '{
        mem_req:      1'b0,
        pc_not_read:  1'b1,
        pc_not_write: 1'b1,
        pc_inc:       1'b0,
        ir_load:      1'b0,
        ex_start:     1'b0,
        halted:       1'b0,
        fault:        1'b0
    };

    // Control levels for the cycle spent in 'st'. ex_start is only raised
    // on the first EXECUTE cycle, which the caller flags with first_exec.
    function automatic ctrl_t decode_ctrl(input state_e st, input logic first_exec);
        ctrl_t c;
        c = CTRL_RESET;
        case (st)
            ST_FETCH_ADDR, ST_FETCH_WAIT: begin
                c.mem_req     = 1'b1;
                c.pc_not_read = 1'b0;
            end
            ST_LATCH: begin
                c.pc_inc  = 1'b1;
                c.ir_load = 1'b1;
            end
            ST_EXECUTE: c.ex_start     = first_exec;
            ST_JUMP:    c.pc_not_write = 1'b0;
            ST_HALTED:  c.halted       = 1'b1;
            ST_FAULT:   c.fault        = 1'b1;
            default:    c              = CTRL_RESET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer
//   Memory-acknowledge watchdog for the fetch sequencer. Counts cycles spent
//   waiting for mem_ack and flags the cycle on which the wait would reach
//   ACK_TIMEOUT.
// Ports:
//   clk     in   system clock, rising edge
//   notClr  in   asynchronous active-low reset (count -> 0)
//   clear   in   zero the count at the next edge
//   inc     in   one more cycle waited without an acknowledge
//   expire  out  this increment brings the count to ACK_TIMEOUT
module fetch_timer
    import fetch_sequencer_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic notClr,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Clear wins over increment so a fresh fetch always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + ONE;
        end
    end

    // Compare against ACK_TIMEOUT-1 so the timeout is seen in the same cycle
    // the count would reach ACK_TIMEOUT, without a wider comparator.
    assign expire = inc && (count_q == LAST_COUNT);

    always_ff @(posedge clk or negedge notClr) begin
        if (!notClr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Control FSM sequencing the program counter through fetch, increment and
//   jump load, with req/ack handshake to memory and start/done handshake to
//   the execute stage. All outputs are registered and decoded from state.
// Configuration:
//   FETCH_SEQ_SINGLE_STEP_EN - adds the 'step' input; the FSM halts after
//   every instruction and each rising edge of step runs exactly one more.
// Ports:
//   clk          in   system clock, rising edge
//   notClr       in   asynchronous active-low reset
//   start        in   leave IDLE / resume from HALTED
//   halt         in   stop at the next instruction boundary
//   mem_ack      in   instruction word is on data_bus
//   ex_done      in   execute stage finished
//   ex_jump      in   with ex_done: load PC from data_bus
//   step         in   (single-step builds only) run one instruction
//   mem_req      out  memory read request
//   pc_notRead   out  active-low, PC drives the bus
//   pc_notWrite  out  active-low, PC loads from data_bus
//   pc_inc       out  PC increment strobe
//   ir_load      out  instruction register capture strobe
//   ex_start     out  one-cycle execute start pulse
//   halted       out  FSM in HALTED
//   fault        out  FSM in FAULT (sticky until reset)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic notClr,
    input  logic start,
    input  logic halt,
    input  logic mem_ack,
    input  logic ex_done,
    input  logic ex_jump,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    input  logic step,
`endif
    output logic mem_req,
    output logic pc_notRead,
    output logic pc_notWrite,
    output logic pc_inc,
    output logic ir_load,
    output logic ex_start,
    output logic halted,
    output logic fault
);

    state_e state_d;
    state_e state_q;
    ctrl_t  ctrl_d;
    ctrl_t  ctrl_q;

    logic timer_clear;
    logic timer_inc;
    logic timer_expire;
    logic boundary_halt;
    logic resume;

    fetch_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk    (clk),
        .notClr (notClr),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expire (timer_expire)
    );

    // The watchdog restarts on every fetch and only counts wait cycles in
    // which memory has not answered.
    always_comb begin
        timer_clear = (state_q == ST_FETCH_ADDR);
        timer_inc   = (state_q == ST_FETCH_WAIT) && !mem_ack;
    end

`ifdef FETCH_SEQ_SINGLE_STEP_EN
    logic step_d;
    logic step_q;

    // In single-step builds every instruction boundary stops the FSM, and a
    // held step only counts once thanks to the edge detect.
    always_comb begin
        step_d        = step;
        boundary_halt = 1'b1;
        resume        = (step && !step_q) || (start && !halt);
    end
`else
    always_comb begin
        boundary_halt = halt;
        resume        = start && !halt;
    end
`endif

    // Next-state logic. halt is only looked at when leaving EXECUTE or JUMP,
    // so a halt raised during a fetch lets that instruction finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH_ADDR;
                end
            end
            ST_FETCH_ADDR: state_d = ST_FETCH_WAIT;
            ST_FETCH_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_LATCH;
                end else if (timer_expire) begin
                    state_d = ST_FAULT;
                end
            end
            ST_LATCH: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (ex_done) begin
                    if (ex_jump) begin
                        state_d = ST_JUMP;
                    end else if (boundary_halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH_ADDR;
                    end
                end
            end
            ST_JUMP: state_d = boundary_halt ? ST_HALTED : ST_FETCH_ADDR;
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_FETCH_ADDR;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        // Decoding the next state lets the outputs come straight from flops
        // while still lining up with the state they belong to. EXECUTE is
        // only ever entered from LATCH, which marks its first cycle.
        ctrl_d = decode_ctrl(state_d, state_q == ST_LATCH);
    end

    always_ff @(posedge clk or negedge notClr) begin
        if (!notClr) begin
            state_q <= ST_IDLE;
            ctrl_q  <= CTRL_RESET;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
            step_q  <= step_d;
`endif
        end
    end

    assign mem_req     = ctrl_q.mem_req;
    assign pc_notRead  = ctrl_q.pc_not_read;
    assign pc_notWrite = ctrl_q.pc_not_write;
    assign pc_inc      = ctrl_q.pc_inc;
    assign ir_load     = ctrl_q.ir_load;
    assign ex_start    = ctrl_q.ex_start;
    assign halted      = ctrl_q.halted;
    assign fault       = ctrl_q.fault;

endmodule
